dbus_access_ctrl: RTL

//  Sequencing controller between the memory stage and the data bus. Captures one load/store

---
 rtl/dbus_access_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/dbus_access_ctrl.sv
// dbus_access_ctrl: issues one data-bus access per memory-stage instruction, holds it until data_ok,
// stalls the pipeline meanwhile and drains squashed accesses before accepting new ones.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_access_ctrl
    import dbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  dbus_req_t        req,
    input  logic             advance,
    input  logic             flush,
    output dbus_req_t        dreq,
    input  dbus_resp_t       dresp,
    output logic [63:0]      rdata,
    output logic             rdata_valid,
    output logic             stall,
    output logic             timeout_err,
    output logic [CNT_W-1:0] perf_stall_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE, DRAIN} state_t;

    state_t          state, state_n;
    dbus_req_t       req_q;
    logic [TW-1:0]   wait_cnt;
    logic            busy, data_ok, unused_addr_ok;

    // addr_ok plays no part in sequencing: data_ok alone ends an access
    assign unused_addr_ok = dresp.addr_ok;
    assign data_ok        = dresp.data_ok;
    assign busy           = state == ISSUE || state == DRAIN;
    assign rdata_valid    = state == DONE;
    assign stall          = req_valid & ((!flush & state != DONE) | state == DRAIN);

    always_comb begin
        dreq = '0;
        if (busy) begin
            dreq       = req_q;
            dreq.valid = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid && !flush) state_n = ISSUE;
            ISSUE:   if (flush) state_n = data_ok ? IDLE : DRAIN;
                     else if (data_ok) state_n = DONE;
            DRAIN:   if (data_ok) state_n = IDLE;
            DONE:    if (advance || flush) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            req_q          <= '0;
            rdata          <= '0;
            wait_cnt       <= '0;
            timeout_err    <= 1'b0;
            perf_stall_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == ISSUE) req_q <= req;
            if (state == ISSUE && state_n == DONE) rdata <= dresp.data;
            if (state_n != state && (state_n == ISSUE || state_n == DRAIN))
                wait_cnt <= '0;
            else if (busy && !data_ok && wait_cnt != TW'(TIMEOUT_CYCLES))
                wait_cnt <= wait_cnt + 1'b1;
            // sticky: the access keeps waiting, software sees the flag
            if (busy && !data_ok && wait_cnt >= TW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
            if (stall) perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
endmodule
